// File: rtl/pcileech_tlp_axis_upsizer.sv
// Packs a narrow DW-granular TLP stream into OUT_DW-wide beats with first/last/BAR
// sideband, buffering committed beats in a small FIFO to absorb sink backpressure.
module pcileech_tlp_axis_upsizer #(
  parameter int IN_DW  = 2,
  parameter int OUT_DW = 4,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [32*IN_DW-1:0]   s_data,
  input  logic [IN_DW-1:0]      s_keepdw,
  input  logic                  s_valid,
  input  logic                  s_last,
  input  logic [6:0]            s_bar,
  output logic                  s_ready,
  output logic [32*OUT_DW-1:0]  m_tdata,
  output logic [OUT_DW-1:0]     m_tkeepdw,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic [8:0]            m_tuser,
  input  logic                  m_tready,
  output logic                  m_has_data,
  output logic                  err_keep,
  output logic [31:0]           tlp_count
);

  localparam int FW = $clog2(OUT_DW + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [32*OUT_DW-1:0] asm_q;
  logic [FW-1:0]        fill_q;
  logic                 in_tlp_q;
  logic                 first_q;
  logic [6:0]           bar_q;
  logic                 err_q;
  logic [31:0]          tlp_q;

  logic [32*OUT_DW-1:0] mem_data  [DEPTH];
  logic [OUT_DW-1:0]    mem_keep  [DEPTH];
  logic                 mem_last  [DEPTH];
  logic                 mem_first [DEPTH];
  logic [6:0]           mem_bar   [DEPTH];
  logic [AW-1:0]        rd_q;
  logic [AW-1:0]        wr_q;
  logic [CW-1:0]        cnt_q;

  logic                 accept;
  logic                 keep_contig;
  logic                 keep_bad;
  logic                 zero_err;
  logic [IN_DW-1:0]     eff_keep;
  logic [FW-1:0]        n_dw;
  logic [FW-1:0]        new_fill;
  logic                 commit;
  logic                 pop;
  logic [32*OUT_DW-1:0] asm_next;
  logic [OUT_DW-1:0]    keep_out;
  logic                 first_cur;
  logic [6:0]           bar_cur;

  assign s_ready  = rst_n && (cnt_q < CW'(DEPTH));
  assign accept   = s_valid && s_ready;
  assign m_tvalid = (cnt_q != '0);
  assign pop      = m_tvalid && m_tready;

  // Bad keep patterns are treated as full beats so the stream stays DW-aligned.
  always_comb begin
    keep_contig = ((s_keepdw & (s_keepdw + IN_DW'(1))) == '0);
    keep_bad    = !keep_contig || (!s_last && !(&s_keepdw));
    eff_keep    = keep_bad ? '1 : s_keepdw;
    zero_err    = s_last && (s_keepdw == '0) && (fill_q == '0);
    n_dw = '0;
    for (int unsigned i = 0; i < IN_DW; i++) begin
      n_dw = n_dw + FW'(eff_keep[i]);
    end
    new_fill = fill_q + n_dw;
    commit   = accept && (s_last || (new_fill == FW'(OUT_DW)));
    asm_next = asm_q;
    for (int unsigned i = 0; i < IN_DW; i++) begin
      if (32'(fill_q) + i < OUT_DW) begin
        asm_next[32*(32'(fill_q) + i) +: 32] = eff_keep[i] ? s_data[32*i +: 32] : 32'h0;
      end
    end
    keep_out = '0;
    for (int unsigned j = 0; j < OUT_DW; j++) begin
      keep_out[j] = (j < 32'(new_fill));
    end
    first_cur = in_tlp_q ? first_q : 1'b1;
    bar_cur   = in_tlp_q ? bar_q : s_bar;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q    <= '0;
      fill_q   <= '0;
      in_tlp_q <= 1'b0;
      first_q  <= 1'b0;
      bar_q    <= '0;
      err_q    <= 1'b0;
      tlp_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        if (commit) begin
          asm_q  <= '0;
          fill_q <= '0;
          wr_q   <= wr_q + AW'(1);
        end else begin
          asm_q  <= asm_next;
          fill_q <= new_fill;
        end
        in_tlp_q <= !s_last;
        bar_q    <= bar_cur;
        first_q  <= commit ? 1'b0 : first_cur;
        if (keep_bad || zero_err) err_q <= 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
        if (mem_last[rd_q]) tlp_q <= tlp_q + 32'd1;
      end
      unique case ({commit, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem_data[wr_q]  <= asm_next;
      mem_keep[wr_q]  <= keep_out;
      mem_last[wr_q]  <= s_last;
      mem_first[wr_q] <= first_cur;
      mem_bar[wr_q]   <= bar_cur;
    end
  end

  // Head fields are gated so the bus reads zero whenever nothing is buffered.
  assign m_tdata    = m_tvalid ? mem_data[rd_q] : '0;
  assign m_tkeepdw  = m_tvalid ? mem_keep[rd_q] : '0;
  assign m_tlast    = m_tvalid && mem_last[rd_q];
  assign m_tuser    = m_tvalid ? {mem_bar[rd_q], mem_last[rd_q], mem_first[rd_q]} : '0;
  assign m_has_data = m_tvalid;
  assign err_keep   = err_q;
  assign tlp_count  = tlp_q;

endmodule

// File: tb/tb_pcileech_tlp_axis_upsizer.sv
// Randomised bench for pcileech_tlp_axis_upsizer: TLPs are described as DW lists and the
// expected output beats are derived by chunking each TLP into OUT_DW-sized pieces.
module tb_pcileech_tlp_axis_upsizer;

  localparam int IN_DW  = 2;
  localparam int OUT_DW = 4;
  localparam int DEPTH  = 4;

  typedef logic [32*OUT_DW+OUT_DW+1+9-1:0] beat_t;

  logic                 clk;
  logic                 rst_n;
  logic [32*IN_DW-1:0]  s_data;
  logic [IN_DW-1:0]     s_keepdw;
  logic                 s_valid;
  logic                 s_last;
  logic [6:0]           s_bar;
  logic                 s_ready;
  logic [32*OUT_DW-1:0] m_tdata;
  logic [OUT_DW-1:0]    m_tkeepdw;
  logic                 m_tvalid;
  logic                 m_tlast;
  logic [8:0]           m_tuser;
  logic                 m_tready;
  logic                 m_has_data;
  logic                 err_keep;
  logic [31:0]          tlp_count;

  pcileech_tlp_axis_upsizer #(.IN_DW(IN_DW), .OUT_DW(OUT_DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_keepdw(s_keepdw), .s_valid(s_valid),
    .s_last(s_last), .s_bar(s_bar), .s_ready(s_ready), .m_tdata(m_tdata),
    .m_tkeepdw(m_tkeepdw), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tready(m_tready), .m_has_data(m_has_data), .err_keep(err_keep), .tlp_count(tlp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t obs_q[$];
  beat_t exp_q[$];
  int    total;
  int    bad;
  int    drive_timeouts;

  // m_tready only changes just after posedge, so a beat seen here completes at the next edge.
  always @(negedge clk) begin
    if (m_tvalid === 1'b1 && m_tready === 1'b1)
      obs_q.push_back({m_tdata, m_tkeepdw, m_tlast, m_tuser});
  end

  function automatic void model_tlp(input logic [31:0] dws [16], input int n, input logic [6:0] bar);
    logic [127:0] d;
    logic [3:0]   k;
    int           c;
    int           nb;
    bit           lst;
    nb = (n + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      k = '0;
      c = (n - 4*b > 4) ? 4 : n - 4*b;
      for (int j = 0; j < c; j++) begin
        d[32*j +: 32] = dws[4*b + j];
        k[j] = 1'b1;
      end
      lst = (b == nb - 1);
      exp_q.push_back({d, k, lst, bar, lst, (b == 0)});
    end
  endfunction

  task automatic fill_rand(output logic [31:0] dws [16]);
    for (int i = 0; i < 16; i++) dws[i] = $urandom;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [1:0] k, input bit last, input logic [6:0] bar);
    int g;
    @(negedge clk);
    s_data = d; s_keepdw = k; s_last = last; s_bar = bar; s_valid = 1'b1;
    g = 0;
    while (!s_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) drive_timeouts++;
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; s_keepdw = '0;
  endtask

  task automatic send_tlp(input logic [31:0] dws [16], input int n, input logic [6:0] bar, input bit gaps);
    for (int b = 0; 2*b < n; b++) begin
      logic [63:0] d;
      int rem;
      rem = n - 2*b;
      d[31:0]  = dws[2*b];
      d[63:32] = (rem > 1) ? dws[2*b+1] : $urandom;
      drive_beat(d, (rem > 1) ? 2'b11 : 2'b01, (rem <= 2), (b == 0) ? bar : 7'($urandom));
      if (gaps && $urandom_range(0, 3) == 0) idle();
    end
  endtask

  task automatic wait_drain(input int n, output bit ok);
    int g;
    g = 0;
    while (obs_q.size() < n && g < 1000) begin
      @(negedge clk);
      g++;
    end
    ok = (obs_q.size() >= n);
    repeat (4) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_tready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_keepdw = '0; s_data = '0; s_bar = '0;
    m_tready = 1'b1;
    #1;
    total++;
    if ({m_tvalid, m_tdata, m_tkeepdw, m_tlast, m_tuser, m_has_data, s_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b data=%h keep=%b user=%h ready=%b want all 0",
               m_tvalid, m_tdata, m_tkeepdw, m_tuser, s_ready);
    end
    total++;
    if ({err_keep, tlp_count} !== 33'd0) begin
      bad++;
      $display("FAIL reset_status got err=%b tlp_count=%0d want 0/0", err_keep, tlp_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] dws [16];
    bit ok;
    obs_q.delete(); exp_q.delete();
    fill_rand(dws);
    send_tlp(dws, 3, 7'd2, 1'b0);
    idle();
    total++;
    if (m_tvalid !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency got m_tvalid=%b want 1", m_tvalid);
    end
    model_tlp(dws, 3, 7'd2);
    wait_drain(1, ok);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      beat_t got = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL basic_beat%0d got=%h want=%h", i, got, exp_q[i]);
      end
    end
    total++;
    if (!ok || obs_q[0][8:0] !== 9'h00B) begin
      bad++;
      $display("FAIL basic_tuser got=%h want=00b", ok ? obs_q[0][8:0] : 9'hx);
    end
    total++;
    if (tlp_count !== 32'd1) begin
      bad++;
      $display("FAIL basic_tlp_count got=%0d want=1", tlp_count);
    end
  endtask

  task automatic test_full_tlp();
    logic [31:0] dws [16];
    bit ok;
    obs_q.delete(); exp_q.delete();
    fill_rand(dws);
    send_tlp(dws, 8, 7'd7, 1'b0);
    idle();
    model_tlp(dws, 8, 7'd7);
    wait_drain(2, ok);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL full_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      beat_t got = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL full_beat%0d got=%h want=%h", i, got, exp_q[i]);
      end
    end
    total++;
    if (!ok || {obs_q[0][8:0], obs_q[1][8:0]} !== {9'h01D, 9'h01E}) begin
      bad++;
      $display("FAIL full_tuser got=%h want=01d/01e", ok ? {obs_q[0][8:0], obs_q[1][8:0]} : 18'hx);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [16];
    logic [31:0] b [16];
    bit ok;
    obs_q.delete(); exp_q.delete();
    fill_rand(a);
    fill_rand(b);
    send_tlp(a, 3, 7'd4, 1'b0);
    send_tlp(b, 4, 7'd5, 1'b0);
    idle();
    model_tlp(a, 3, 7'd4);
    model_tlp(b, 4, 7'd5);
    wait_drain(2, ok);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      beat_t got = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_beat%0d got=%h want=%h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] t [5][16];
    bit ok;
    apply_reset();
    @(posedge clk);
    #1 m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fill_rand(t[i]);
      model_tlp(t[i], 4, 7'(2 + i));
    end
    for (int i = 0; i < 4; i++) send_tlp(t[i], 4, 7'(2 + i), 1'b0);
    idle();
    total++;
    if ({s_ready, m_tvalid} !== 2'b01) begin
      bad++;
      $display("FAIL bp_full got s_ready=%b m_tvalid=%b want 0/1", s_ready, m_tvalid);
    end
    fork
      begin
        send_tlp(t[4], 4, 7'd6, 1'b0);
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        total++;
        if ({s_ready, s_valid, obs_q.size() == 0} !== 3'b011) begin
          bad++;
          $display("FAIL bp_hold got s_ready=%b s_valid=%b popped=%0d want 0/1/0", s_ready, s_valid, obs_q.size());
        end
        @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    wait_drain(5, ok);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      beat_t got = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL bp_beat%0d got=%h want=%h", i, got, exp_q[i]);
      end
    end
    total++;
    if (tlp_count !== 32'd5) begin
      bad++;
      $display("FAIL bp_tlp_count got=%0d want=5", tlp_count);
    end
  endtask

  task automatic test_err_keep();
    logic [31:0] a [16];
    logic [31:0] b [16];
    bit ok;
    apply_reset();
    fill_rand(a);
    fill_rand(b);
    drive_beat({a[1], a[0]}, 2'b01, 1'b0, 7'd6);
    drive_beat({a[3], a[2]}, 2'b11, 1'b1, 7'd0);
    idle();
    total++;
    if (err_keep !== 1'b1) begin
      bad++;
      $display("FAIL err_set got=%b want=1", err_keep);
    end
    model_tlp(a, 4, 7'd6);
    send_tlp(b, 5, 7'd3, 1'b0);
    idle();
    model_tlp(b, 5, 7'd3);
    wait_drain(3, ok);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL err_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      beat_t got = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL err_beat%0d got=%h want=%h", i, got, exp_q[i]);
      end
    end
    total++;
    if (err_keep !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky got=%b want=1", err_keep);
    end
    apply_reset();
    total++;
    if (err_keep !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b want=0", err_keep);
    end
    drive_beat({a[1], a[0]}, 2'b10, 1'b1, 7'd3);
    idle();
    model_tlp(a, 2, 7'd3);
    wait_drain(1, ok);
    total++;
    if ({err_keep, obs_q.size() == 1} !== 2'b11 || obs_q[0] !== exp_q[0]) begin
      bad++;
      $display("FAIL err_noncontig got err=%b beats=%0d beat=%h want 1/1 %h",
               err_keep, obs_q.size(), ok ? obs_q[0] : 'x, exp_q[0]);
    end
  endtask

  task automatic test_zero_keep();
    logic [31:0] a [16];
    bit ok;
    apply_reset();
    fill_rand(a);
    drive_beat({a[1], a[0]}, 2'b11, 1'b0, 7'd8);
    drive_beat(64'($urandom), 2'b00, 1'b1, 7'd0);
    idle();
    total++;
    if (err_keep !== 1'b0) begin
      bad++;
      $display("FAIL zero_partial_err got=%b want=0", err_keep);
    end
    model_tlp(a, 2, 7'd8);
    drive_beat(64'($urandom), 2'b00, 1'b1, 7'd2);
    idle();
    exp_q.push_back({128'h0, 4'b0000, 1'b1, 7'd2, 1'b1, 1'b1});
    total++;
    if (err_keep !== 1'b1) begin
      bad++;
      $display("FAIL zero_empty_err got=%b want=1", err_keep);
    end
    wait_drain(2, ok);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL zero_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      beat_t got = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL zero_beat%0d got=%h want=%h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a [16];
    bit ok;
    apply_reset();
    @(posedge clk);
    #1 m_tready = 1'b0;
    fill_rand(a);
    send_tlp(a, 4, 7'd2, 1'b0);
    send_tlp(a, 4, 7'd2, 1'b0);
    drive_beat({a[1], a[0]}, 2'b11, 1'b0, 7'd5);
    @(posedge clk);
    #1 rst_n = 1'b0; s_valid = 1'b0;
    #1;
    total++;
    if ({m_tvalid, m_tdata, m_tkeepdw, m_tlast, m_tuser, m_has_data, s_ready, tlp_count} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got valid=%b keep=%b user=%h ready=%b cnt=%0d want all 0",
               m_tvalid, m_tkeepdw, m_tuser, s_ready, tlp_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete(); exp_q.delete();
    @(posedge clk);
    #1 m_tready = 1'b1;
    fill_rand(a);
    send_tlp(a, 3, 7'd3, 1'b0);
    idle();
    model_tlp(a, 3, 7'd3);
    wait_drain(1, ok);
    total++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      bad++;
      $display("FAIL midreset_beat got beats=%0d beat=%h want 1 %h", obs_q.size(), ok ? obs_q[0] : 'x, exp_q[0]);
    end
    total++;
    if (!ok || obs_q[0][0] !== 1'b1 || tlp_count !== 32'd1) begin
      bad++;
      $display("FAIL midreset_first got first=%b tlp_count=%0d want 1/1", ok ? obs_q[0][0] : 1'bx, tlp_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] a [16];
    logic [31:0] base;
    bit ok;
    bit done;
    int n;
    logic [6:0] bar;
    obs_q.delete(); exp_q.delete();
    base = tlp_count;
    done = 1'b0;
    fork
      begin
        for (int t = 0; t < 40; t++) begin
          fill_rand(a);
          n = $urandom_range(1, 12);
          bar = 7'($urandom_range(2, 8));
          model_tlp(a, n, bar);
          send_tlp(a, n, bar, 1'b1);
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 m_tready = ($urandom_range(0, 3) != 0);
        end
        m_tready = 1'b1;
      end
    join
    wait_drain(exp_q.size(), ok);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      beat_t got = (i < obs_q.size()) ? obs_q[i] : 'x;
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_beat%0d got=%h want=%h", i, got, exp_q[i]);
      end
    end
    total++;
    if (tlp_count !== base + 32'd40) begin
      bad++;
      $display("FAIL rand_tlp_count got=%0d want=%0d", tlp_count, base + 32'd40);
    end
    total++;
    if (drive_timeouts !== 0) begin
      bad++;
      $display("FAIL drive_timeouts got=%0d want=0", drive_timeouts);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    drive_timeouts = 0;
    test_reset();
    test_basic();
    test_full_tlp();
    test_back_to_back();
    test_backpressure();
    test_err_keep();
    test_zero_keep();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
